// File: rtl/park_pkg.sv
// park_pkg: shared lane state encoding, timer width and default car park capacity.
package park_pkg;
   typedef enum logic [1:0] {IDLE, OPEN, PASS, CLOSE} lane_state_t;
   localparam int TIMER_W      = 16;
   localparam int CAPACITY_DEF = 10;
endpackage

// File: rtl/parking_gate_ctrl_if.sv
// parking_gate_ctrl_if: sensor, occupancy and barrier/event signals of the gate controller.
interface parking_gate_ctrl_if;
   logic [7:0] occ_count;
   logic       ent_arrive, ent_auth, ent_pass;
   logic       ext_arrive, ext_auth, ext_pass;
   logic       ent_barrier, ext_barrier;
   logic       car_in, car_out;
   logic       ent_reject, ent_timeout, ext_timeout;
   modport master (
      output occ_count, ent_arrive, ent_auth, ent_pass, ext_arrive, ext_auth, ext_pass,
      input  ent_barrier, ext_barrier, car_in, car_out, ent_reject, ent_timeout, ext_timeout
   );
   modport slave (
      input  occ_count, ent_arrive, ent_auth, ent_pass, ext_arrive, ext_auth, ext_pass,
      output ent_barrier, ext_barrier, car_in, car_out, ent_reject, ent_timeout, ext_timeout
   );
endinterface

// File: rtl/park_gate_lane.sv
// park_gate_lane: one barrier lane FSM with open timeout, close hold and done/timeout pulses.
module park_gate_lane
   import park_pkg::*;
#(
   parameter int OPEN_TIMEOUT = 1000,
   parameter int CLOSE_CYC    = 50
) (
   input  logic clk,
   input  logic reset,
   input  logic arrive_i,
   input  logic auth_i,
   input  logic pass_i,
   input  logic permit_i,
   output logic barrier_o,
   output logic done_o,
   output logic timeout_o,
   output logic idle_o
);
   lane_state_t        state_q;
   logic [TIMER_W-1:0] timer_q;
   logic               barrier_q, done_q, timeout_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         barrier_q <= 1'b0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         timer_q   <= &timer_q ? timer_q : timer_q + 1'b1;
         case (state_q)
            IDLE: if (arrive_i && auth_i && permit_i) begin
               state_q   <= OPEN;
               timer_q   <= '0;
               barrier_q <= 1'b1;
            end
            OPEN: if (pass_i) begin
               state_q <= PASS;
               timer_q <= '0;
            end else if (timer_q == TIMER_W'(OPEN_TIMEOUT - 1)) begin
               state_q   <= CLOSE;
               timer_q   <= '0;
               barrier_q <= 1'b0;
               timeout_q <= 1'b1;
            end
            // the car has cleared the passage loop: this is the only point a car event is born
            PASS: if (!pass_i) begin
               state_q   <= CLOSE;
               timer_q   <= '0;
               barrier_q <= 1'b0;
               done_q    <= 1'b1;
            end
            CLOSE: if (timer_q == TIMER_W'(CLOSE_CYC - 1)) begin
               state_q <= IDLE;
               timer_q <= '0;
            end
         endcase
      end
   end
   assign barrier_o = barrier_q;
   assign done_o    = done_q;
   assign timeout_o = timeout_q;
   assign idle_o    = state_q == IDLE;
endmodule

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: entry/exit barrier controller emitting non-coincident car_in/car_out events.
// Define PARK_DEBOUNCE_EN to add a DEBOUNCE_CYC-cycle debouncer behind every sensor synchroniser.
module parking_gate_ctrl
   import park_pkg::*;
#(
   parameter int CAPACITY     = CAPACITY_DEF,
   parameter int OPEN_TIMEOUT = 1000,
   parameter int CLOSE_CYC    = 50
`ifdef PARK_DEBOUNCE_EN
   ,parameter int DEBOUNCE_CYC = 8
`endif
) (
   input logic                clk,
   input logic                reset,
   parking_gate_ctrl_if.slave gate_if
);
   logic [5:0] pins, sync1_q, sync2_q, sens;
   logic       permit, ent_done, ext_done, ent_idle, unused_ext_idle;
   logic       rej_fire, rej_q, rej_arm_q, defer_q;
   assign pins = {gate_if.ext_pass, gate_if.ext_auth, gate_if.ext_arrive,
                  gate_if.ent_pass, gate_if.ent_auth, gate_if.ent_arrive};
   always_ff @(posedge clk) begin
      sync1_q <= reset ? '0 : pins;
      sync2_q <= reset ? '0 : sync1_q;
   end
`ifdef PARK_DEBOUNCE_EN
   localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
   logic [DB_W-1:0] db_cnt_q [6];
   logic [5:0]      db_q;
   // a sensor output flips only after DEBOUNCE_CYC consecutive samples disagree with it
   always_ff @(posedge clk) begin
      for (int i = 0; i < 6; i++) begin
         if (reset || sync2_q[i] == db_q[i]) db_cnt_q[i] <= '0;
         else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) db_cnt_q[i] <= '0;
         else db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
         if (reset) db_q[i] <= 1'b0;
         else if (sync2_q[i] != db_q[i] && db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) db_q[i] <= sync2_q[i];
      end
   end
   assign sens = db_q;
`else
   assign sens = sync2_q;
`endif
   assign permit = gate_if.occ_count < 8'(CAPACITY);
   park_gate_lane #(.OPEN_TIMEOUT(OPEN_TIMEOUT), .CLOSE_CYC(CLOSE_CYC)) u_ent (
      .clk       (clk),
      .reset     (reset),
      .arrive_i  (sens[0]),
      .auth_i    (sens[1]),
      .pass_i    (sens[2]),
      .permit_i  (permit),
      .barrier_o (gate_if.ent_barrier),
      .done_o    (ent_done),
      .timeout_o (gate_if.ent_timeout),
      .idle_o    (ent_idle)
   );
   park_gate_lane #(.OPEN_TIMEOUT(OPEN_TIMEOUT), .CLOSE_CYC(CLOSE_CYC)) u_ext (
      .clk       (clk),
      .reset     (reset),
      .arrive_i  (sens[3]),
      .auth_i    (sens[4]),
      .pass_i    (sens[5]),
      .permit_i  (1'b1),
      .barrier_o (gate_if.ext_barrier),
      .done_o    (ext_done),
      .timeout_o (gate_if.ext_timeout),
      .idle_o    (unused_ext_idle)
   );
   assign rej_fire = ent_idle & sens[0] & sens[1] & ~permit & rej_arm_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         rej_q     <= 1'b0;
         rej_arm_q <= 1'b1;
         defer_q   <= 1'b0;
      end else begin
         rej_q     <= rej_fire;
         rej_arm_q <= ~sens[1] | (rej_arm_q & ~rej_fire);
         defer_q   <= ent_done & ext_done;
      end
   end
   // entry wins a tie; the exit event slips one cycle (exit lane is then in CLOSE, so no overlap)
   assign gate_if.car_in     = ent_done;
   assign gate_if.car_out    = defer_q | (ext_done & ~ent_done);
   assign gate_if.ent_reject = rej_q;
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: directed scenarios checked every cycle against a timestamp-based lane model.
module tb_parking_gate_ctrl;
   localparam int CAP = 10, OT = 1000, CC = 50;
`ifdef PARK_DEBOUNCE_EN
   localparam int DB = 8, LAT = 2 + DB;
`else
   localparam int LAT = 2;
`endif
   localparam int P_IDLE = 0, P_OPEN = 1, P_PASS = 2, P_CLOSE = 3;
   logic clk = 1'b0, reset = 1'b1;
   parking_gate_ctrl_if bus ();
   parking_gate_ctrl dut (.clk(clk), .reset(reset), .gate_if(bus));
   always #5 clk = ~clk;
   int n_cmp = 0, n_bad = 0, cyc = 0;
   int pc [7];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0d want %0d", nm, cyc, act, exp);
      end
   endtask
   function automatic logic outv(input int k);
      case (k)
         0: return bus.ent_barrier;
         1: return bus.ext_barrier;
         2: return bus.car_in;
         3: return bus.car_out;
         4: return bus.ent_reject;
         5: return bus.ent_timeout;
         default: return bus.ext_timeout;
      endcase
   endfunction
   // model: lane phase plus the edge it was entered; events derive from elapsed edges
   int   ph [2], t0 [2], pend;
   logic armed;
   logic [5:0] d1, d2;
   logic m_bar [2], m_to [2], m_in, m_out, m_rej;
`ifdef PARK_DEBOUNCE_EN
   logic [5:0] db;
   logic [5:0] win [$];
`endif
   always @(posedge clk) begin
      logic [5:0] f, pins;
      logic dn [2];
      logic arr, au, ps, perm, same;
      cyc++;
      pins = {bus.ext_pass, bus.ext_auth, bus.ext_arrive, bus.ent_pass, bus.ent_auth, bus.ent_arrive};
      if (reset) begin
         ph = '{P_IDLE, P_IDLE}; t0 = '{0, 0}; pend = 0; armed = 1'b1; d1 = '0; d2 = '0;
         m_bar = '{1'b0, 1'b0}; m_to = '{1'b0, 1'b0}; m_in = 1'b0; m_out = 1'b0; m_rej = 1'b0;
`ifdef PARK_DEBOUNCE_EN
         db = '0; win.delete();
`endif
      end else begin
`ifdef PARK_DEBOUNCE_EN
         f = db;
`else
         f = d2;
`endif
         m_rej = 1'b0;
         for (int l = 0; l < 2; l++) begin
            arr = f[3*l]; au = f[3*l+1]; ps = f[3*l+2];
            perm = (l == 1) || (int'(bus.occ_count) < CAP);
            dn[l] = 1'b0; m_to[l] = 1'b0;
            if (ph[l] == P_IDLE) begin
               if (l == 0 && arr && au && !perm && armed) m_rej = 1'b1;
               if (arr && au && perm) begin ph[l] = P_OPEN; t0[l] = cyc; end
            end else if (ph[l] == P_OPEN) begin
               if (ps) begin ph[l] = P_PASS; t0[l] = cyc; end
               else if (cyc - t0[l] == OT) begin ph[l] = P_CLOSE; t0[l] = cyc; m_to[l] = 1'b1; end
            end else if (ph[l] == P_PASS) begin
               if (!ps) begin ph[l] = P_CLOSE; t0[l] = cyc; dn[l] = 1'b1; end
            end else if (cyc - t0[l] == CC) ph[l] = P_IDLE;
            m_bar[l] = ph[l] == P_OPEN || ph[l] == P_PASS;
         end
         armed = !f[1] ? 1'b1 : (m_rej ? 1'b0 : armed);
         pend += int'(dn[1]);
         m_in = dn[0];
         m_out = !dn[0] && pend > 0;
         if (m_out) pend--;
`ifdef PARK_DEBOUNCE_EN
         win.push_back(d2);
         if (win.size() > DB) void'(win.pop_front());
         if (win.size() == DB)
            for (int b = 0; b < 6; b++) begin
               same = 1'b1;
               foreach (win[i]) if (win[i][b] != win[0][b]) same = 1'b0;
               if (same && win[0][b] != db[b]) db[b] = win[0][b];
            end
`endif
         d2 = d1; d1 = pins;
      end
   end
   always @(negedge clk) if (cyc > 0) begin
      chk("ent_barrier", bus.ent_barrier, m_bar[0]);
      chk("ext_barrier", bus.ext_barrier, m_bar[1]);
      chk("car_in", bus.car_in, m_in);
      chk("car_out", bus.car_out, m_out);
      chk("ent_reject", bus.ent_reject, m_rej);
      chk("ent_timeout", bus.ent_timeout, m_to[0]);
      chk("ext_timeout", bus.ext_timeout, m_to[1]);
      chk("in_out_exclusive", bus.car_in & bus.car_out, 1'b0);
      for (int k = 0; k < 7; k++) pc[k] += int'(outv(k));
   end
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic wait_hi(input int k, input int lim, output int n);
      n = 0;
      while (!outv(k) && n < lim) begin tick(1); n++; end
   endtask
   task automatic do_reset();
      reset = 1'b1;
      {bus.ent_arrive, bus.ent_auth, bus.ent_pass, bus.ext_arrive, bus.ext_auth, bus.ext_pass} = '0;
      tick(3);
      reset = 1'b0;
   endtask
   initial begin
      int n;
      int b [7];
      bus.occ_count = 8'd0;
      do_reset();
      for (int k = 0; k < 7; k++) chk("reset_out", outv(k), 1'b0);
      // entry with space: open, pass, car_in, then close hold before reopening
      b = pc; bus.occ_count = 8'd3; bus.ent_arrive = 1'b1; bus.ent_auth = 1'b1;
      wait_hi(0, 50, n); chk("t1_open_lat", n, LAT + 1);
      bus.ent_pass = 1'b1; tick(20); bus.ent_pass = 1'b0;
      wait_hi(2, 60, n); chk("t1_car_in_lat", n, LAT + 1);
      chk("t1_barrier_closed", bus.ent_barrier, 1'b0);
      wait_hi(0, 100, n); chk("t1_close_hold", n, CC + 1);
      chk("t1_car_in_count", pc[2] - b[2], 1);
      // full park: one reject per request, re-armed by auth low; capacity-1 grants
      do_reset(); b = pc; bus.occ_count = 8'd10; bus.ent_arrive = 1'b1; bus.ent_auth = 1'b1;
      wait_hi(4, 50, n); chk("t2_reject_lat", n, LAT + 1);
      tick(15);
      chk("t2_reject_once", pc[4] - b[4], 1);
      bus.ent_auth = 1'b0; tick(20); bus.ent_auth = 1'b1;
      wait_hi(4, 50, n); chk("t2_rearm_lat", n, LAT + 1);
      tick(5);
      chk("t2_reject_twice", pc[4] - b[4], 2);
      chk("t2_no_open", pc[0] - b[0], 0);
      chk("t2_no_car_in", pc[2] - b[2], 0);
      bus.occ_count = 8'd9;
      wait_hi(0, 10, n); chk("t2_cap_minus1_open", n, 1);
      // exit lane never passed: timeout after OPEN_TIMEOUT cycles, no car_out
      do_reset(); b = pc; bus.ext_arrive = 1'b1; bus.ext_auth = 1'b1;
      wait_hi(1, 50, n); chk("t3_open_lat", n, LAT + 1);
      bus.ext_arrive = 1'b0; bus.ext_auth = 1'b0;
      wait_hi(6, 1100, n); chk("t3_timeout_at", n, OT);
      chk("t3_barrier_closed", bus.ext_barrier, 1'b0);
      chk("t3_no_car_out", pc[3] - b[3], 0);
      // both lanes complete in the same cycle
      do_reset(); b = pc; bus.occ_count = 8'd3;
      {bus.ent_arrive, bus.ent_auth, bus.ext_arrive, bus.ext_auth} = 4'hf;
      wait_hi(0, 50, n); chk("t4_ent_open", n, LAT + 1);
      chk("t4_ext_open", bus.ext_barrier, 1'b1);
      {bus.ent_arrive, bus.ent_auth, bus.ext_arrive, bus.ext_auth} = 4'h0;
      bus.ent_pass = 1'b1; bus.ext_pass = 1'b1; tick(10);
      bus.ent_pass = 1'b0; bus.ext_pass = 1'b0;
      wait_hi(2, 60, n); chk("t4_car_in_lat", n, LAT + 1);
      chk("t4_out_held", bus.car_out, 1'b0);
      tick(1);
      chk("t4_out_next", bus.car_out, 1'b1);
      chk("t4_in_gone", bus.car_in, 1'b0);
      tick(3);
      chk("t4_counts", (pc[2] - b[2]) * 10 + (pc[3] - b[3]), 11);
      // reset while the entry car is in the passage
      do_reset(); b = pc; bus.occ_count = 8'd3; bus.ent_arrive = 1'b1; bus.ent_auth = 1'b1;
      wait_hi(0, 50, n);
      bus.ent_pass = 1'b1; tick(LAT + 4);
      chk("t5_in_pass", bus.ent_barrier, 1'b1);
      reset = 1'b1; tick(1);
      chk("t5_barrier_drop", bus.ent_barrier, 1'b0);
      {bus.ent_arrive, bus.ent_auth, bus.ent_pass} = 3'b000;
      tick(3); reset = 1'b0; tick(LAT + 20);
      chk("t5_no_car_in", pc[2] - b[2], 0);
`ifdef PARK_DEBOUNCE_EN
      // short glitch on the passage loop is filtered, a long pulse is a real car
      do_reset(); b = pc; bus.occ_count = 8'd3; bus.ent_arrive = 1'b1; bus.ent_auth = 1'b1;
      wait_hi(0, 50, n);
      bus.ent_pass = 1'b1; tick(5); bus.ent_pass = 1'b0; tick(30);
      chk("t6_glitch_open", bus.ent_barrier, 1'b1);
      chk("t6_glitch_no_car", pc[2] - b[2], 0);
      bus.ent_pass = 1'b1; tick(9); bus.ent_pass = 1'b0;
      wait_hi(2, 60, n); chk("t6_pulse_lat", n, LAT + 1);
      tick(3);
      chk("t6_pulse_car", pc[2] - b[2], 1);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
